// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants for the UART transmit scheduler: arbiter states, source
// encodings and the round-robin pick helper.
package uart_sched_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  typedef logic [1:0] src_t;

  localparam src_t SRC_NONE = 2'd0;
  localparam src_t SRC_ECHO = 2'd1;
  localparam src_t SRC_BTN  = 2'd2;
  localparam src_t SRC_REP  = 2'd3;

  // First requester after `last` in the rotation echo -> button -> repeat -> echo.
  function automatic src_t rr_pick(input src_t last, input logic [3:1] req);
    src_t cand;
    rr_pick = SRC_NONE;
    cand    = last;
    for (int i = 0; i < 3; i++) begin
      cand = (cand == SRC_REP) ? SRC_ECHO : cand + 2'd1;
      if (rr_pick == SRC_NONE && req[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Valid/ready byte handshake between the scheduler and the UART serializer.
interface uart_tx_scheduler_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] tx_src;
  logic       tx_ready;

  modport master (output tx_valid, tx_data, tx_src, input tx_ready);
  modport slave  (input tx_valid, tx_data, tx_src, output tx_ready);
endinterface

// File: rtl/uart_echo_fifo.sv
// Small power-of-two synchronous FIFO holding received bytes awaiting echo.
module uart_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between the send button, the auto-repeat timer
// and the receive echo path, offering bytes to the serializer by valid/ready.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000,
  parameter int ECHO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [7:0]          sw_data,
  input  logic                btn_raw,
  input  logic                repeat_sw,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  uart_tx_scheduler_if.master tx,
  output logic                echo_overflow,
  output logic                busy
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RP_W = $clog2(REPEAT_CYCLES);
  localparam logic [RP_W-1:0] REP_RELOAD = RP_W'(REPEAT_CYCLES - 1);

  logic            btn_s1, btn_s2, rep_s1, rep_s2;
  logic            btn_db, btn_db_q, btn_rise;
  logic [DB_W-1:0] db_cnt;
  logic [RP_W-1:0] rep_cnt;
  logic            pend_btn, pend_rep;
  logic [7:0]      btn_byte;
  logic [0:0]      state;
  src_t            last_src, pick;
  logic            grant;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [7:0]      fifo_dout;

  uart_echo_fifo #(.DEPTH(ECHO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (fifo_pop),
    .din   (rx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Synchronizers and debounce: the level moves only after a full run of
  // DEBOUNCE_CYCLES cycles that all disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {btn_s2, btn_s1} <= 2'b00;
      {rep_s2, rep_s1} <= 2'b00;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      {btn_s2, btn_s1} <= {btn_s1, btn_raw};
      {rep_s2, rep_s1} <= {rep_s1, repeat_sw};
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign btn_rise = btn_db && !btn_db_q;
  assign pick     = rr_pick(last_src, {pend_rep, pend_btn, !fifo_empty});
  assign grant    = (state == ST_IDLE) && ena && (pick != SRC_NONE);
  assign fifo_pop = grant && (pick == SRC_ECHO);

  // Request flags; a new request in the granting cycle wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_btn <= 1'b0;
      btn_byte <= 8'h00;
      pend_rep <= 1'b0;
      rep_cnt  <= REP_RELOAD;
    end else begin
      if (grant && pick == SRC_BTN) pend_btn <= 1'b0;
      if (btn_rise && !pend_btn) begin
        pend_btn <= 1'b1;
        btn_byte <= sw_data;
      end
      if (grant && pick == SRC_REP) pend_rep <= 1'b0;
      if (!rep_s2) begin
        rep_cnt  <= REP_RELOAD;
        pend_rep <= 1'b0;
      end else if (rep_cnt == '0) begin
        rep_cnt  <= REP_RELOAD;
        pend_rep <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_overflow <= 1'b0;
    end else if (rx_valid && fifo_full && !fifo_pop) begin
      echo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      tx.tx_src   <= SRC_NONE;
      last_src    <= SRC_REP;
    end else begin
      case (state)
        ST_IDLE: if (grant) begin
          tx.tx_valid <= 1'b1;
          tx.tx_src   <= pick;
          last_src    <= pick;
          state       <= ST_OFFER;
          case (pick)
            SRC_ECHO: tx.tx_data <= fifo_dout;
            SRC_BTN:  tx.tx_data <= btn_byte;
            default:  tx.tx_data <= sw_data;
          endcase
        end
        default: if (tx.tx_ready) begin
          tx.tx_valid <= 1'b0;
          tx.tx_src   <= SRC_NONE;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == ST_OFFER) || pend_btn || pend_rep || !fifo_empty;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized checks of uart_tx_scheduler against expected offers.
module tb_uart_tx_scheduler;
  localparam int DB = 4;
  localparam int RP = 20;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic       btn_raw = 1'b0, repeat_sw = 1'b0, rx_valid = 1'b0;
  logic [7:0] sw_data = 8'h00, rx_data = 8'h00;
  logic       echo_overflow, busy;

  uart_tx_scheduler_if txi();

  uart_tx_scheduler #(.DEBOUNCE_CYCLES(DB), .REPEAT_CYCLES(RP), .ECHO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .sw_data       (sw_data),
    .btn_raw       (btn_raw),
    .repeat_sw     (repeat_sw),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .tx            (txi),
    .echo_overflow (echo_overflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [1:0] s; logic [7:0] d; } rec_t;
  rec_t got[$];
  always @(negedge clk)
    if (rst_n && txi.tx_valid && txi.tx_ready)
      got.push_back('{cyc, txi.tx_src, txi.tx_data});

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Returns the cycle at which tx_valid is first seen high, or -1 on timeout.
  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (txi.tx_valid) begin
        at = cyc;
        break;
      end
    end
    tick(1);
  endtask

  initial begin
    int c0, at;
    logic [7:0] e1, e2, x, y, z;
    logic [7:0] expq[$];

    txi.tx_ready = 1'b0;
    tick(2);
    check("rst_tx_valid", txi.tx_valid, 1'b0);
    check("rst_tx_src", txi.tx_src, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", echo_overflow, 1'b0);
    rst_n = 1'b1;
    ena = 1'b1;
    txi.tx_ready = 1'b1;
    tick(3);

    // Bouncy button, then a clean rise
    got.delete();
    sw_data = 8'hC9;
    for (int i = 0; i < 3; i++) begin
      btn_raw = 1'b1; tick(1);
      btn_raw = 1'b0; tick(1);
    end
    btn_raw = 1'b1;
    c0 = cyc;
    wait_valid(20, at);
    check("btn_latency", at - c0, 2 + DB + 1 + 1);
    tick(20);
    btn_raw = 1'b0;
    tick(15);
    check("btn_count", got.size(), 1);
    check("btn_data", got[0].d, 8'hC9);
    check("btn_src", got[0].s, 2'd2);

    // Echo fill while disabled, overflow, then drain in order
    got.delete();
    ena = 1'b0;
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'((i + 1) * 17));
    check("ovf_before", echo_overflow, 1'b0);
    push(8'h55);
    check("ovf_after", echo_overflow, 1'b1);
    check("busy_pending", busy, 1'b1);
    tick(3);
    check("no_grant_disabled", got.size(), 0);
    ena = 1'b1;
    txi.tx_ready = 1'b1;
    tick(14);
    check("echo_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) begin
      check("echo_data", got[i].d, 8'((i + 1) * 17));
      check("echo_src", got[i].s, 2'd1);
      if (i > 0) check("echo_spacing", got[i].c - got[i-1].c, 2);
    end
    check("ovf_sticky", echo_overflow, 1'b1);

    // Auto-repeat
    got.delete();
    sw_data = 8'hA5;
    repeat_sw = 1'b1;
    c0 = cyc;
    tick(95);
    repeat_sw = 1'b0;
    tick(60);
    check("rep_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) begin
      check("rep_data", got[i].d, 8'hA5);
      check("rep_src", got[i].s, 2'd3);
      check("rep_time", got[i].c - c0, 2 + RP + 1 + RP * i);
    end

    // Three-way contention after reset
    ena = 1'b0;
    do_reset();
    e1 = 8'($urandom);
    e2 = 8'($urandom);
    push(e1);
    push(e2);
    sw_data = 8'h3C;
    btn_raw = 1'b1;
    repeat_sw = 1'b1;
    tick(15);
    sw_data = 8'h7E;
    tick(15);
    got.delete();
    ena = 1'b1;
    tick(8);
    repeat_sw = 1'b0;
    btn_raw = 1'b0;
    tick(10);
    check("rr_count", got.size(), 4);
    check("rr0_src", got[0].s, 2'd1);
    check("rr0_data", got[0].d, e1);
    check("rr1_src", got[1].s, 2'd2);
    check("rr1_data", got[1].d, 8'h3C);
    check("rr2_src", got[2].s, 2'd3);
    check("rr2_data", got[2].d, 8'h7E);
    check("rr3_src", got[3].s, 2'd1);
    check("rr3_data", got[3].d, e2);

    // ena dropped during a stalled offer
    do_reset();
    got.delete();
    txi.tx_ready = 1'b0;
    x = 8'($urandom);
    y = 8'($urandom);
    push(x);
    tick(2);
    ena = 1'b0;
    push(y);
    tick(3);
    check("hold_valid", txi.tx_valid, 1'b1);
    check("hold_data", txi.tx_data, x);
    check("hold_src", txi.tx_src, 2'd1);
    txi.tx_ready = 1'b1;
    tick(6);
    check("ena_low_valid", txi.tx_valid, 1'b0);
    check("ena_low_count", got.size(), 1);
    check("ena_low_busy", busy, 1'b1);
    ena = 1'b1;
    wait_valid(5, at);
    check("ena_back_seen", at >= 0, 1'b1);
    tick(2);
    check("ena_back_count", got.size(), 2);
    check("ena_back_data", got[1].d, y);

    // Asynchronous reset in the middle of an offer
    do_reset();
    txi.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    check("pre_rst_ovf", echo_overflow, 1'b1);
    check("pre_rst_valid", txi.tx_valid, 1'b1);
    got.delete();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", txi.tx_valid, 1'b0);
    check("arst_src", txi.tx_src, 2'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_ovf", echo_overflow, 1'b0);
    tick(2);
    rst_n = 1'b1;
    txi.tx_ready = 1'b1;
    tick(10);
    check("post_rst_quiet", got.size(), 0);
    z = 8'($urandom);
    push(z);
    tick(4);
    check("post_rst_count", got.size(), 1);
    check("post_rst_data", got[0].d, z);

    // Random echo traffic with random backpressure and enable
    do_reset();
    got.delete();
    for (int i = 0; i < 300; i++) begin
      txi.tx_ready = 1'($urandom_range(0, 1));
      ena = ($urandom_range(0, 7) != 0);
      if ((expq.size() - got.size()) < 3 && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        expq.push_back(rx_data);
      end else begin
        rx_valid = 1'b0;
      end
      tick(1);
    end
    rx_valid = 1'b0;
    ena = 1'b1;
    txi.tx_ready = 1'b1;
    tick(30);
    check("rand_count", got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      check("rand_data", got[i].d, expq[i]);
      check("rand_src", got[i].s, 2'd1);
    end
    check("rand_ovf", echo_overflow, 1'b0);
    check("rand_idle_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit-side scheduler for the `tt_um_Uart_Transciver` top level. It shares the single UART transmitter between three requesters:
- a debounced one-shot send button, which sends the switch byte;
- an auto-repeat switch, which sends the switch byte every `REPEAT_CYCLES`;
- an echo path, which retransmits every received byte through a small FIFO.

It sits between the top-level pins/receiver and the UART TX serializer, and drives the serializer through a valid/ready handshake.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: stable cycles required before the button level is accepted.
- `REPEAT_CYCLES`, default 1000: period between auto-repeat requests; legal range ≥ 2.
- `ECHO_DEPTH`, default 4: echo FIFO entries; must be a power of 2.

Ports (one clock; asynchronous active-low reset):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ena` in 1: design enable; when low, no new grants are issued.
- `sw_data` in 8: switch byte (`ui_in`).
- `btn_raw` in 1: send button (`uio_in[0]`); asynchronous and bouncy.
- `repeat_sw` in 1: auto-repeat switch (`uio_in[1]`); asynchronous.
- `rx_valid` in 1: one-cycle strobe from the receiver carrying a completed byte.
- `rx_data` in 8: received byte; valid when `rx_valid` is high.
- `tx_ready` in 1: serializer is idle and can accept a byte.
- `tx_valid` out 1: byte offered to the serializer.
- `tx_data` out 8: byte being offered.
- `tx_src` out 2: source of the current offer (0 none, 1 echo, 2 button, 3 repeat).
- `echo_overflow` out 1: sticky flag; set when a byte is dropped because the FIFO is full.
- `busy` out 1: high in OFFER state, or when any request is pending.

## Operation
- **Button path:**
  - `btn_raw` passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level updates only after `DEBOUNCE_CYCLES` consecutive cycles of an unchanged synced value.
  - A rising edge of the debounced level sets `pend_btn` and captures `sw_data` into `btn_byte`.
  - An edge while `pend_btn` is already set is merged and ignored; `btn_byte` is not updated.
- **Repeat path:**
  - `repeat_sw` passes through a 2-flop synchronizer.
  - While the synced level is high, a down-counter loads `REPEAT_CYCLES-1`. On reaching 0 it sets `pend_rep` and reloads.
  - The repeat byte is `sw_data` sampled at grant time.
  - When the synced level goes low, the counter reloads and an ungranted `pend_rep` is cleared.
- **Echo path:**
  - `rx_valid` pushes `rx_data` into the `ECHO_DEPTH` FIFO. Pushes are accepted regardless of `ena`.
  - A push into a full FIFO is dropped and sets `echo_overflow`.
  - A push and a pop in the same cycle on a full FIFO is accepted.
  - Pointers wrap modulo `ECHO_DEPTH`; the count is `$clog2(ECHO_DEPTH)+1` bits wide.
- **Arbiter FSM** (states IDLE, OFFER):
  - **IDLE:** if `ena` is high and any request is pending (`pend_btn`, `pend_rep`, FIFO not empty):
    - grant round-robin starting after `last_src`, in order echo → button → repeat → echo;
    - register `tx_data` and `tx_src`, and set `tx_valid`;
    - clear the granted pending flag, or pop the FIFO;
    - update `last_src`;
    - go to OFFER.
  - **OFFER:** hold `tx_valid`, `tx_data` and `tx_src` stable. On `tx_valid && tx_ready`, clear `tx_valid`, set `tx_src` to 0 and return to IDLE. There is no timeout.
- `ena` falling during OFFER does not abort the offer; it completes normally. Pending requests and FIFO contents are retained while `ena` is low.
- **Reset:** asynchronous. All outputs go to 0. FSM to IDLE, FIFO empty, pending flags cleared, `last_src` = repeat (so echo wins first), debounced level 0, repeat counter = `REPEAT_CYCLES-1`.

## Timing
- Pending request to `tx_valid` high: 1 cycle (grant registered in IDLE).
- Transfer completes on the `clk` edge where `tx_valid && tx_ready`. The earliest next grant is 1 cycle later, because IDLE is always visited, so back-to-back offers are separated by one idle cycle.
- Button latency from a clean `btn_raw` rise to `pend_btn`: 2 (sync) + `DEBOUNCE_CYCLES` + 1 cycles.
- Repeat: the first `pend_rep` is set `REPEAT_CYCLES` cycles after the synced switch goes high, then every `REPEAT_CYCLES` cycles. A request that fires while the previous one is still pending is merged.
- `rx_valid` is visible as FIFO not-empty on the next cycle.
- `echo_overflow` is set the cycle after the dropped push and is cleared only by reset.

## Structure
- Package `uart_sched_pkg`: FSM state enum {IDLE, OFFER}; `tx_src` encodings `SRC_NONE`/`SRC_ECHO`/`SRC_BTN`/`SRC_REP`.
- Sub-module `uart_echo_fifo`: parameterised synchronous FIFO (push, pop, full, empty, data out), registered storage, asynchronous active-low reset.
- Debounce, repeat timer and arbiter all live in `uart_tx_scheduler`.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_CYCLES`=20, `tx_ready` tied high unless stated.
1. `sw_data`=0xC9; `btn_raw` bounces 0/1 for 3 cycles, then is held high → exactly one offer `tx_data`=0xC9, `tx_src`=2, exactly 2+4+1+1 cycles after the stable rise.
2. `rx_valid` strobes with 0x11, 0x22, 0x33, 0x44, 0x55, `tx_ready`=0 → four bytes stored, 0x55 dropped, `echo_overflow`=1. Releasing `tx_ready` → echoes 0x11, 0x22, 0x33, 0x44 in order with `tx_src`=1.
3. `repeat_sw`=1, `sw_data`=0xA5 for 100 cycles → offers of 0xA5 spaced 20 cycles apart. Dropping `repeat_sw` → no further offers.
4. Echo, button and repeat all pending in the same cycle after reset → grant order echo, button, repeat, then echo again if the FIFO is not empty.
5. `tx_ready`=0 during OFFER and `ena` dropped → `tx_valid`/`tx_data` held. Raising `tx_ready` → transfer completes, then no new grants until `ena` returns.
6. `rst_n` asserted mid-OFFER with FIFO non-empty → `tx_valid`, `tx_src`, `busy`, `echo_overflow` go to 0 immediately. After release, no offers until a new request arrives.
